// File: rtl/csr_trap_unit.sv
// csr_trap_unit
//   Machine-mode CSR file with trap entry/exit and interrupt arbitration.
//   Holds mstatus (MIE/MPIE), mie, mtvec, mscratch, mepc, mcause, mip and the
//   mcycle/minstret counters, and presents the trap vector, saved PC and the
//   highest-priority pending enabled interrupt to the core.
//
// Ports
//   clk           clock
//   rst           asynchronous reset, active low
//   csr_addr      12-bit CSR address
//   csr_op        00 none, 01 write, 10 set, 11 clear
//   csr_src       operand for the CSR op
//   csr_rdata     combinational pre-update value of the addressed CSR
//   csr_illegal   combinational illegal-access flag
//   instr_retire  one instruction retires this cycle
//   trap_req      take a trap this cycle (trap_cause / trap_pc qualify it)
//   mret          return from trap this cycle
//   irq_ext/irq_timer/irq_soft  level-sensitive interrupt lines
//   irq_pending   global-enabled interrupt pending
//   irq_cause     mcause value for the winning interrupt, 0 if none
//   trap_vector   handler address from mtvec (direct or vectored)
//   mepc_out      current mepc
module csr_trap_unit #(
  parameter int          XLEN      = 32,
  parameter int          CNT_W     = 64,
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_src,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            instr_retire,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            irq_pending,
  output logic [XLEN-1:0] irq_cause,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out
);

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Only MSIE(3), MTIE(7), MEIE(11) exist in mie.
  localparam logic [XLEN-1:0] MIE_MASK = 32'h0000_0888;
  // Upper counter halves only exist for 64-bit counters.
  localparam bit HAS_HI = (CNT_W == 64);

  // State
  logic             mie_bit_reg,  mie_bit_next;
  logic             mpie_bit_reg, mpie_bit_next;
  logic [XLEN-1:0]  mie_reg,      mie_next;
  logic [XLEN-1:0]  mtvec_reg,    mtvec_next;
  logic [XLEN-1:0]  mscratch_reg, mscratch_next;
  logic [XLEN-1:0]  mepc_reg,     mepc_next;
  logic [XLEN-1:0]  mcause_reg,   mcause_next;
  logic [XLEN-1:0]  mip_reg,      mip_next;
  logic [CNT_W-1:0] mcycle_reg,   mcycle_next;
  logic [CNT_W-1:0] minstret_reg, minstret_next;

  logic [XLEN-1:0] mstatus_val;
  logic [63:0]     mcycle_ext;
  logic [63:0]     minstret_ext;
  logic            addr_hit;
  logic            wr_nonzero;
  logic            csr_we;
  logic [XLEN-1:0] wdata;

  // MPP is hardwired to M-mode; only MIE and MPIE are real storage.
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_bit_reg, 3'b0, mie_bit_reg, 3'b0};

  // Zero-extended view so the read mux and write merge are width-agnostic;
  // with 32-bit counters the high halves simply read 0.
  assign mcycle_ext   = 64'(mcycle_reg);
  assign minstret_ext = 64'(minstret_reg);

  // Read mux (pre-update value) and address decode
  always_comb begin
    csr_rdata = '0;
    addr_hit  = 1'b1;
    case (csr_addr)
      ADDR_MSTATUS:   csr_rdata = mstatus_val;
      ADDR_MIE:       csr_rdata = mie_reg;
      ADDR_MTVEC:     csr_rdata = mtvec_reg;
      ADDR_MSCRATCH:  csr_rdata = mscratch_reg;
      ADDR_MEPC:      csr_rdata = mepc_reg;
      ADDR_MCAUSE:    csr_rdata = mcause_reg;
      ADDR_MIP:       csr_rdata = mip_reg;
      ADDR_MCYCLE:    csr_rdata = mcycle_ext[31:0];
      ADDR_MINSTRET:  csr_rdata = minstret_ext[31:0];
      ADDR_MCYCLEH:   csr_rdata = mcycle_ext[63:32];
      ADDR_MINSTRETH: csr_rdata = minstret_ext[63:32];
      default:        addr_hit  = 1'b0;
    endcase
  end

  // set/clear with a zero operand is a pure read: no update, never illegal.
  assign wr_nonzero  = (csr_op == OP_WRITE) || (csr_src != '0);
  assign csr_illegal = (csr_op != OP_NONE) &&
                       (!addr_hit || ((csr_addr == ADDR_MIP) && wr_nonzero));
  // Trap and mret both outrank a CSR op and drop it.
  assign csr_we      = (csr_op != OP_NONE) && !csr_illegal && wr_nonzero &&
                       !trap_req && !mret;

  always_comb begin
    case (csr_op)
      OP_WRITE: wdata = csr_src;
      OP_SET:   wdata = csr_rdata | csr_src;
      OP_CLEAR: wdata = csr_rdata & ~csr_src;
      default:  wdata = csr_rdata;
    endcase
  end

  // Next-state logic
  always_comb begin
    logic        cyc_wr_lo, cyc_wr_hi, ret_wr_lo, ret_wr_hi;
    logic [63:0] cyc_merge, ret_merge;

    mie_bit_next  = mie_bit_reg;
    mpie_bit_next = mpie_bit_reg;
    mie_next      = mie_reg;
    mtvec_next    = mtvec_reg;
    mscratch_next = mscratch_reg;
    mepc_next     = mepc_reg;
    mcause_next   = mcause_reg;
    cyc_wr_lo     = 1'b0;
    cyc_wr_hi     = 1'b0;
    ret_wr_lo     = 1'b0;
    ret_wr_hi     = 1'b0;

    mip_next     = '0;
    mip_next[3]  = irq_soft;
    mip_next[7]  = irq_timer;
    mip_next[11] = irq_ext;

    if (trap_req) begin
      mepc_next     = trap_pc & ~32'h3;
      mcause_next   = trap_cause;
      mpie_bit_next = mie_bit_reg;
      mie_bit_next  = 1'b0;
    end else if (mret) begin
      mie_bit_next  = mpie_bit_reg;
      mpie_bit_next = 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_bit_next  = wdata[3];
          mpie_bit_next = wdata[7];
        end
        ADDR_MIE:       mie_next      = wdata & MIE_MASK;
        // Modes 2 and 3 are reserved: the whole write is dropped.
        ADDR_MTVEC:     if (!wdata[1]) mtvec_next = wdata;
        ADDR_MSCRATCH:  mscratch_next = wdata;
        ADDR_MEPC:      mepc_next     = wdata & ~32'h3;
        ADDR_MCAUSE:    mcause_next   = wdata;
        ADDR_MCYCLE:    cyc_wr_lo     = 1'b1;
        ADDR_MINSTRET:  ret_wr_lo     = 1'b1;
        ADDR_MCYCLEH:   cyc_wr_hi     = HAS_HI;
        ADDR_MINSTRETH: ret_wr_hi     = HAS_HI;
        default: ;
      endcase
    end

    // A write to either half replaces that half and skips this cycle's count.
    cyc_merge = mcycle_ext;
    if (cyc_wr_lo) cyc_merge[31:0]  = wdata;
    if (cyc_wr_hi) cyc_merge[63:32] = wdata;
    ret_merge = minstret_ext;
    if (ret_wr_lo) ret_merge[31:0]  = wdata;
    if (ret_wr_hi) ret_merge[63:32] = wdata;

    if (cyc_wr_lo || cyc_wr_hi) mcycle_next = CNT_W'(cyc_merge);
    else                        mcycle_next = mcycle_reg + CNT_W'(1);

    if (ret_wr_lo || ret_wr_hi) minstret_next = CNT_W'(ret_merge);
    else                        minstret_next = minstret_reg + CNT_W'(instr_retire);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_bit_reg  <= 1'b0;
      mpie_bit_reg <= 1'b0;
      mie_reg      <= '0;
      mtvec_reg    <= MTVEC_RST;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
      mip_reg      <= '0;
      mcycle_reg   <= '0;
      minstret_reg <= '0;
    end else begin
      mie_bit_reg  <= mie_bit_next;
      mpie_bit_reg <= mpie_bit_next;
      mie_reg      <= mie_next;
      mtvec_reg    <= mtvec_next;
      mscratch_reg <= mscratch_next;
      mepc_reg     <= mepc_next;
      mcause_reg   <= mcause_next;
      mip_reg      <= mip_next;
      mcycle_reg   <= mcycle_next;
      minstret_reg <= minstret_next;
    end
  end

  // Interrupt arbitration: external > software > timer.
  always_comb begin
    logic [XLEN-1:0] pend_en;
    pend_en     = mip_reg & mie_reg;
    irq_pending = mie_bit_reg & (|pend_en);
    if (pend_en[11])     irq_cause = 32'h8000_000B;
    else if (pend_en[3]) irq_cause = 32'h8000_0003;
    else if (pend_en[7]) irq_cause = 32'h8000_0007;
    else                 irq_cause = '0;
  end

  // Vectored mode only redirects interrupts; exceptions use the base.
  always_comb begin
    logic [XLEN-1:0] base;
    base = {mtvec_reg[31:2], 2'b00};
    if ((mtvec_reg[1:0] == 2'b01) && mcause_reg[31])
      trap_vector = base + {mcause_reg[29:0], 2'b00};
    else
      trap_vector = base;
  end

  assign mepc_out = mepc_reg;

endmodule
